// File: rtl/vec_pkg.sv
// Shared vector-unit definitions: major opcodes, instruction word type
// and the opcode classifier used by the decoder and the instruction queue.
package vec_pkg;

   localparam int VEC_INSN_WIDTH = 32;

   localparam logic [6:0] OPC_OP_V     = 7'h57;
   localparam logic [6:0] OPC_LOAD_FP  = 7'h07;
   localparam logic [6:0] OPC_STORE_FP = 7'h27;

   typedef logic [VEC_INSN_WIDTH-1:0] insn_t;

   function automatic logic is_vec_opc(input logic [6:0] opc);
      return (opc == OPC_OP_V) ||
             (opc == OPC_LOAD_FP) ||
             (opc == OPC_STORE_FP);
   endfunction

endpackage

// File: rtl/vec_insn_queue_mem.sv
// DEPTH x INSN_WIDTH register array for the vector instruction queue:
// one synchronous write port, one asynchronous read port.
module vec_insn_queue_mem
   import vec_pkg::*;
#(
   parameter int INSN_WIDTH = 32,
   parameter int DEPTH      = 4,
   parameter int AW         = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [AW-1:0]         waddr,
   input  logic [INSN_WIDTH-1:0] wdata,
   input  logic [AW-1:0]         raddr,
   output logic [INSN_WIDTH-1:0] rdata
);

   logic [INSN_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/vec_insn_queue.sv
// Instruction buffer in front of the vector decoder (circular FIFO).
// Optional opcode filter: define VEC_INSN_QUEUE_OPCODE_FILTER_EN.
module vec_insn_queue
   import vec_pkg::*;
#(
   parameter int INSN_WIDTH = 32,
   parameter int DEPTH      = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       insn_in_valid,
   output logic                       insn_in_ready,
   input  logic [INSN_WIDTH-1:0]      insn_in,
   output logic                       insn_out_valid,
   input  logic                       insn_out_ready,
   output logic [INSN_WIDTH-1:0]      insn_out,
`ifdef VEC_INSN_QUEUE_OPCODE_FILTER_EN
   output logic                       illegal_insn,
`endif
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0]         rptr;
   logic [PW-1:0]         wptr;
   logic [INSN_WIDTH-1:0] rdata;
   logic                  full;
   logic                  push;
   logic                  pop;
   logic                  opc_ok;
   logic                  store;
   logic                  we;

   // Ready is a function of state only, never of insn_out_ready.
   assign full          = (count == CW'(DEPTH));
   assign insn_in_ready = !full && !rst;
   assign push          = insn_in_valid && insn_in_ready;
   assign pop           = insn_out_valid && insn_out_ready;

`ifdef VEC_INSN_QUEUE_OPCODE_FILTER_EN
   assign opc_ok = is_vec_opc(insn_in[6:0]);
`else
   assign opc_ok = 1'b1;
`endif

   assign store = push && opc_ok;
   assign we    = store && !flush && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         rptr  <= '0;
         wptr  <= '0;
         count <= '0;
      end else if (flush) begin
         rptr  <= '0;
         wptr  <= '0;
         count <= '0;
      end else begin
         if (store) wptr <= wptr + PW'(1);
         if (pop)   rptr <= rptr + PW'(1);
         count <= count + CW'(store) - CW'(pop);
      end
   end

`ifdef VEC_INSN_QUEUE_OPCODE_FILTER_EN
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         illegal_insn <= 1'b0;
      end else begin
         illegal_insn <= push && !opc_ok;
      end
   end
`endif

   vec_insn_queue_mem #(
      .INSN_WIDTH (INSN_WIDTH),
      .DEPTH      (DEPTH),
      .AW         (PW)
   ) u_mem (
      .clk   (clk),
      .we    (we),
      .waddr (wptr),
      .wdata (insn_in),
      .raddr (rptr),
      .rdata (rdata)
   );

   // Zero the word when empty so the decoder never sees stale data.
   assign insn_out_valid = (count != '0);
   assign insn_out       = insn_out_valid ? rdata : '0;

endmodule

// File: tb/tb_vec_insn_queue.sv
// Scoreboard testbench for vec_insn_queue (DEPTH=4, INSN_WIDTH=32).
module tb_vec_insn_queue;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        insn_in_valid;
   logic        insn_in_ready;
   logic [31:0] insn_in;
   logic        insn_out_valid;
   logic        insn_out_ready;
   logic [31:0] insn_out;
   logic [2:0]  count;
`ifdef VEC_INSN_QUEUE_OPCODE_FILTER_EN
   logic        illegal_insn;
`endif

   logic [31:0] sb [$];
   logic        ill_exp;
   int          tests;
   int          fails;

   always #5 clk = ~clk;

   vec_insn_queue #(.INSN_WIDTH(32), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst            (rst),
      .flush          (flush),
      .insn_in_valid  (insn_in_valid),
      .insn_in_ready  (insn_in_ready),
      .insn_in        (insn_in),
      .insn_out_valid (insn_out_valid),
      .insn_out_ready (insn_out_ready),
      .insn_out       (insn_out),
`ifdef VEC_INSN_QUEUE_OPCODE_FILTER_EN
      .illegal_insn   (illegal_insn),
`endif
      .count          (count)
   );

   function automatic logic opc_ok_f(input logic [31:0] w);
`ifdef VEC_INSN_QUEUE_OPCODE_FILTER_EN
      return (w[6:0] == 7'h57) || (w[6:0] == 7'h07) || (w[6:0] == 7'h27);
`else
      return (w[0] === w[0]);
`endif
   endfunction

   function automatic logic [36:0] st();
      return {insn_in_ready, insn_out_valid, count, insn_out};
   endfunction

   function automatic logic [36:0] exp_status();
      logic        rdy;
      logic        vld;
      logic [31:0] w;
      rdy = !rst && (sb.size() < DEPTH);
      vld = (sb.size() != 0);
      w   = vld ? sb[0] : 32'h0;
      return {rdy, vld, 3'(sb.size()), w};
   endfunction

   task automatic drive(input logic v, input logic [31:0] d,
                        input logic r, input logic f);
      insn_in_valid  = v;
      insn_in        = d;
      insn_out_ready = r;
      flush          = f;
      #1;
   endtask

   task automatic step();
      logic mpush;
      logic mpop;
      if (rst) begin
         sb.delete();
         ill_exp = 1'b0;
      end else if (flush) begin
         sb.delete();
         ill_exp = 1'b0;
      end else begin
         mpop  = insn_out_ready && (sb.size() != 0);
         mpush = insn_in_valid && (sb.size() < DEPTH);
         if (mpop) void'(sb.pop_front());
         if (mpush && opc_ok_f(insn_in)) sb.push_back(insn_in);
         ill_exp = mpush && !opc_ok_f(insn_in);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      step();
      tests++;
      if (st() !== exp_status()) begin
         fails++;
         $display("FAIL reset_during got=%h exp=%h", st(), exp_status());
      end
      rst = 1'b0;
      #1;
      tests++;
      if (st() !== exp_status()) begin
         fails++;
         $display("FAIL reset_release got=%h exp=%h", st(), exp_status());
      end
   endtask

   task automatic test_single();
      drive(1'b1, 32'h0000_0057, 1'b0, 1'b0);
      step();
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 32'h0, 1'b0, 1'b0);
         tests++;
         if (st() !== exp_status()) begin
            fails++;
            $display("FAIL single_hold got=%h exp=%h", st(), exp_status());
         end
         step();
      end
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      step();
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      tests++;
      if (st() !== exp_status()) begin
         fails++;
         $display("FAIL single_empty got=%h exp=%h", st(), exp_status());
      end
   endtask

   task automatic test_full();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'hA000_0057 | (32'(i) << 8), 1'b0, 1'b0);
         step();
      end
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      tests++;
      if (st() !== exp_status()) begin
         fails++;
         $display("FAIL full_cnt got=%h exp=%h", st(), exp_status());
      end
      drive(1'b1, 32'hBAD0_0057, 1'b1, 1'b0);
      tests++;
      if (st() !== exp_status()) begin
         fails++;
         $display("FAIL full_refuse got=%h exp=%h", st(), exp_status());
      end
      step();
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      tests++;
      if (st() !== exp_status()) begin
         fails++;
         $display("FAIL full_after_pop got=%h exp=%h", st(), exp_status());
      end
      for (int i = 0; i < DEPTH + 1 && sb.size() != 0; i++) begin
         drive(1'b0, 32'h0, 1'b1, 1'b0);
         tests++;
         if (st() !== exp_status()) begin
            fails++;
            $display("FAIL full_drain got=%h exp=%h", st(), exp_status());
         end
         step();
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 32'hB000_0027 | (32'(i) << 12), 1'b0, 1'b0);
         step();
      end
      for (int i = 2; i < 12; i++) begin
         drive(1'b1, 32'hB000_0007 | (32'(i) << 12), 1'b1, 1'b0);
         tests++;
         if (st() !== exp_status() || count !== 3'd2) begin
            fails++;
            $display("FAIL b2b got=%h exp=%h", st(), exp_status());
         end
         step();
      end
      for (int i = 0; i < DEPTH + 1 && sb.size() != 0; i++) begin
         drive(1'b0, 32'h0, 1'b1, 1'b0);
         tests++;
         if (st() !== exp_status()) begin
            fails++;
            $display("FAIL b2b_drain got=%h exp=%h", st(), exp_status());
         end
         step();
      end
   endtask

   task automatic test_flush();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'hC000_0057 | (32'(i) << 16), 1'b0, 1'b0);
         step();
      end
      drive(1'b1, 32'hDEAD_0057, 1'b0, 1'b1);
      tests++;
      if (st() !== exp_status()) begin
         fails++;
         $display("FAIL flush_pre got=%h exp=%h", st(), exp_status());
      end
      step();
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      tests++;
      if (st() !== exp_status()) begin
         fails++;
         $display("FAIL flush_post got=%h exp=%h", st(), exp_status());
      end
      drive(1'b1, 32'hC0DE_0027, 1'b0, 1'b0);
      step();
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      tests++;
      if (st() !== exp_status()) begin
         fails++;
         $display("FAIL flush_refill got=%h exp=%h", st(), exp_status());
      end
      step();
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 32'hE000_0057 | (32'(i) << 20), 1'b0, 1'b0);
         step();
      end
      rst = 1'b1;
      drive(1'b1, 32'hE0FF_0057, 1'b0, 1'b0);
      tests++;
      if (st() !== exp_status()) begin
         fails++;
         $display("FAIL rst_mid_during got=%h exp=%h", st(), exp_status());
      end
      step();
      rst = 1'b0;
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      tests++;
      if (st() !== exp_status()) begin
         fails++;
         $display("FAIL rst_mid_after got=%h exp=%h", st(), exp_status());
      end
   endtask

`ifdef VEC_INSN_QUEUE_OPCODE_FILTER_EN
   task automatic test_filter();
      drive(1'b1, 32'h0000_0013, 1'b0, 1'b0);
      step();
      drive(1'b1, 32'h0200_0057, 1'b0, 1'b0);
      tests++;
      if (illegal_insn !== ill_exp || st() !== exp_status()) begin
         fails++;
         $display("FAIL filter_drop got=%b/%h exp=%b/%h",
                  illegal_insn, st(), ill_exp, exp_status());
      end
      step();
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      tests++;
      if (illegal_insn !== ill_exp || st() !== exp_status()) begin
         fails++;
         $display("FAIL filter_keep got=%b/%h exp=%b/%h",
                  illegal_insn, st(), ill_exp, exp_status());
      end
      drive(1'b1, 32'h0000_0013, 1'b1, 1'b1);
      step();
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      tests++;
      if (illegal_insn !== ill_exp || st() !== exp_status()) begin
         fails++;
         $display("FAIL filter_flush got=%b/%h exp=%b/%h",
                  illegal_insn, st(), ill_exp, exp_status());
      end
   endtask
`else
   task automatic test_nofilter();
      drive(1'b1, 32'h0000_0013, 1'b0, 1'b0);
      step();
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      tests++;
      if (st() !== exp_status()) begin
         fails++;
         $display("FAIL nofilter_store got=%h exp=%h", st(), exp_status());
      end
      step();
   endtask
`endif

   initial begin
      tests   = 0;
      fails   = 0;
      ill_exp = 1'b0;
      test_reset();
      test_single();
      test_full();
      test_back_to_back();
      test_flush();
      test_reset_mid();
`ifdef VEC_INSN_QUEUE_OPCODE_FILTER_EN
      test_filter();
`else
      test_nofilter();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/vec_insn_queue.md
Name: vec_insn_queue

Overview:
- Instruction buffer that sits directly upstream of the vector instruction decoder.
- Accepts 32-bit vector instructions from the scalar host over a valid/ready handshake and buffers them in a small circular FIFO.
- Presents the oldest instruction, registered, to the decoder with its own valid/ready handshake.
- Decouples host issue from vector-unit stalls and supports a pipeline flush.

Parameters:
- INSN_WIDTH, 32, width of one instruction word.
- DEPTH, 4, number of FIFO entries; must be a power of 2 and at least 2.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- flush  input  1  discard all buffered instructions.
- insn_in_valid  input  1  host presents an instruction.
- insn_in_ready  output  1  queue can accept an instruction.
- insn_in  input  INSN_WIDTH  instruction word from host.
- insn_out_valid  output  1  insn_out holds a valid instruction.
- insn_out_ready  input  1  decoder/issue consumes insn_out.
- insn_out  output  INSN_WIDTH  oldest buffered instruction, feeds the decoder.
- count  output  $clog2(DEPTH)+1  number of entries currently held.

Behaviour:
- Reset (rst=1 at a clock edge) sets:
  - read pointer, write pointer and count to 0;
  - insn_out_valid=0 and insn_out=0;
  - insn_in_ready=0 during the reset cycle, and 1 on the first cycle after reset is released.
- Storage and pointers:
  - Storage is a DEPTH-entry register array.
  - Read and write pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
  - Full and empty are derived from count (count==DEPTH means full; count==0 means empty), not from pointer comparison.
- Push and pop:
  - push = insn_in_valid & insn_in_ready.
  - pop = insn_out_valid & insn_out_ready.
  - insn_in_ready = !full & !rst. It depends only on state, never combinationally on insn_out_ready.
  - When full, the queue accepts no push even if a pop occurs in the same cycle. This is deliberate: no combinational path from insn_out_ready to insn_in_ready.
- Output:
  - insn_out and insn_out_valid are driven from the entry at the read pointer: insn_out_valid = (count!=0).
  - insn_out is 0 whenever insn_out_valid=0, so the decoder never sees stale data.
  - Latency: an instruction pushed into an empty queue at edge N is visible on insn_out from cycle N+1. There is no same-cycle bypass.
- Simultaneous push and pop with 0<count<DEPTH: count is unchanged, both pointers advance and ordering is preserved.
- Pop when empty is impossible because insn_out_valid=0; insn_out_ready is ignored.
- insn_out must hold stable while insn_out_valid=1 and insn_out_ready=0.
- Flush:
  - At the edge where flush=1, count and both pointers return to 0, and a push in that same cycle is dropped.
  - insn_in_ready remains !full as evaluated before the flush. The host must not treat a handshake during flush as accepted.
  - From the next cycle, insn_out_valid=0.
- Reset has priority over flush; flush has priority over push and pop.
- Reset asserted mid-stream discards all entries. There is no partial drain.

Optional Feature:
- Macro: VEC_INSN_QUEUE_OPCODE_FILTER_EN.
- When defined:
  - Bits [6:0] of each handshaken instruction are checked against the OP-V (7'h57), LOAD-FP (7'h07) and STORE-FP (7'h27) major opcodes.
  - A non-matching instruction is accepted (handshake completes) but is not written and count does not increment.
  - An extra output, illegal_insn (1 bit), pulses high for exactly one cycle after the edge at which it was dropped.
  - illegal_insn resets to 0 and is suppressed if flush is asserted in the same cycle.
- When undefined: every accepted instruction is stored unmodified, and the illegal_insn port does not exist.

Decomposition:
- Shared package vec_pkg holds:
  - localparams OPC_OP_V=7'h57, OPC_LOAD_FP=7'h07, OPC_STORE_FP=7'h27;
  - a typedef for the instruction word, logic [INSN_WIDTH-1:0].
- The decoder and this queue both import vec_pkg.
- Pointers, count and control stay in vec_insn_queue.
- One natural sub-module: vec_insn_queue_mem, the DEPTH x INSN_WIDTH register array with write port (we, waddr, wdata) and asynchronous read port (raddr, rdata).

Test Plan:
- Reset, then push 0x00000057 at cycle 1 with insn_out_ready=0 → cycle 2: insn_out_valid=1, insn_out=0x00000057, count=1; values hold until insn_out_ready=1.
- Push 4 words A0..A3 with insn_out_ready=0 → count=4, insn_in_ready=0. A fifth push with insn_out_ready=1 is refused; A0 pops, and the next cycle count=3 and insn_in_ready=1.
- Continuous push and pop of 10 words with count held at 2 → output order matches input order exactly across pointer wrap; count stays 2.
- With count=3, assert flush together with insn_in_valid=1 → next cycle count=0 and insn_out_valid=0; the flushed-cycle word never appears on insn_out.
- With count=2, assert rst for 1 cycle → next cycle count=0, insn_out_valid=0, insn_out=0, insn_in_ready=1.
- With VEC_INSN_QUEUE_OPCODE_FILTER_EN defined, push 0x00000013 then 0x02000057 → first word: handshake completes, illegal_insn=1 for one cycle, count stays 0; second word is stored and appears on insn_out.
